// File: rtl/sub_pkg.sv
// Shared definitions for the serial subtractor and the benches that use it.
// Holds the FSM state type and the default operand width.
package sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
// Purely combinational.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing (a - b - bin) LSB first over WIDTH cycles.
// Results are held in output registers until the next operation completes.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_diff;
    logic [CW-1:0]    r_count;
    logic             r_borrow;
    logic             r_bout;
    logic             r_done;

    logic [WIDTH-1:0] w_a_shr;
    logic [WIDTH-1:0] w_b_shr;
    logic [WIDTH-1:0] w_shift_in;
    logic             w_d;
    logic             w_borrow;
    logic             w_accept;
    logic             w_last;

    // Operands are shifted right each cycle so bit 0 is always the current bit.
    full_subtractor_bit u_bit (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_borrow)
    );

    // Next-state and control decode.
    always_comb begin
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (r_count == CW'(WIDTH - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Shift networks; new result bits enter at the MSB end.
    always_comb begin
        w_a_shr    = '0;
        w_b_shr    = '0;
        w_shift_in = '0;
        for (int i = 0; i < WIDTH - 1; i++) begin
            w_a_shr[i]    = r_a[i+1];
            w_b_shr[i]    = r_b[i+1];
            w_shift_in[i] = r_shift[i+1];
        end
        w_shift_in[WIDTH-1] = w_d;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: operand capture, bit processing and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_shift  <= '0;
            r_diff   <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_borrow <= bin;
                r_shift  <= '0;
                r_count  <= '0;
            end else if (r_state == RUN) begin
                r_a      <= w_a_shr;
                r_b      <= w_b_shr;
                r_borrow <= w_borrow;
                r_shift  <= w_shift_in;
                r_count  <= r_count + CW'(1);
                if (w_last) begin
                    r_diff <= w_shift_in;
                    r_bout <= w_borrow;
                end else begin
                    r_diff <= r_diff;
                    r_bout <= r_bout;
                end
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios, exhaustive
// sweep, and a per-cycle comparison against an arithmetic reference model.
module tb_serial_subtractor;
    import sub_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         bin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int checks     = 0;
    int errors     = 0;
    int done_count = 0;
    bit chk_en     = 1'b0;

    // Reference model state: operation result computed with plain arithmetic,
    // published after W clock edges.
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    bit           m_bout = 1'b0;
    logic [W-1:0] m_diff = '0;
    logic [W:0]   m_res  = '0;
    int           m_left = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_diff = '0;
            m_bout = 1'b0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_res  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
                    m_busy = 1'b1;
                    m_left = W;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_diff = m_res[W-1:0];
                    m_bout = m_res[W];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_diff", 32'(diff), 32'(m_diff));
            check("cyc_bout", 32'(bout), 32'(m_bout));
            if (done) done_count++;
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                      output int lat, output int busy_cyc);
        start = 1'b1;
        a     = ta;
        b     = tb;
        bin   = tbin;
        @(negedge clk);
        start    = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            errors++;
            $display("FAIL op_timeout: got no done expected done within 20 cycles");
        end
    endtask

    initial begin
        int lat;
        int bc;
        int dc0;
        logic [4:0] ev;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst = 1'b0;

        // 1: basic subtraction and latency
        @(negedge clk);
        op(4'b0111, 4'b0010, 1'b0, lat, bc);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_busy_cycles", 32'(bc), 32'd4);
        check("t1_busy_in_done", 32'(busy), 32'd0);
        check("t1_diff", 32'(diff), 32'h5);
        check("t1_bout", 32'(bout), 32'd0);
        check("t1_model_diff", 32'(m_diff), 32'h5);

        // 2: borrow-out cases
        @(negedge clk);
        op(4'b0010, 4'b0111, 1'b0, lat, bc);
        check("t2a_diff", 32'(diff), 32'hB);
        check("t2a_bout", 32'(bout), 32'd1);
        @(negedge clk);
        op(4'b0000, 4'b0000, 1'b1, lat, bc);
        check("t2b_diff", 32'(diff), 32'hF);
        check("t2b_bout", 32'(bout), 32'd1);
        check("t2b_model_bout", 32'(m_bout), 32'd1);

        // 3: back-to-back with start in the done cycle
        @(negedge clk);
        op(4'b1100, 4'b0000, 1'b1, lat, bc);
        check("t3a_diff", 32'(diff), 32'hB);
        check("t3a_bout", 32'(bout), 32'd0);
        start = 1'b1;
        a     = 4'b0100;
        b     = 4'b0001;
        bin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 20) begin
            check("t3_hold_diff", 32'(diff), 32'hB);
            @(negedge clk);
            lat++;
        end
        check("t3b_latency", 32'(lat), 32'd4);
        check("t3b_diff", 32'(diff), 32'h2);
        check("t3b_bout", 32'(bout), 32'd0);

        // 4: start during RUN is ignored, operands changes have no effect
        @(negedge clk);
        start = 1'b1;
        a     = 4'b1001;
        b     = 4'b0011;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        a     = 4'b1111;
        b     = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        a     = 4'b1010;
        b     = 4'b0101;
        dc0   = done_count;
        wait_done(lat);
        check("t4_diff", 32'(diff), 32'h6);
        check("t4_bout", 32'(bout), 32'd0);
        repeat (8) @(negedge clk);
        check("t4_single_done", 32'(done_count - dc0), 32'd1);

        // 5: reset mid-operation aborts it
        start = 1'b1;
        a     = 4'b1101;
        b     = 4'b0010;
        bin   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_diff", 32'(diff), 32'd0);
        check("t5_bout", 32'(bout), 32'd0);
        rst = 1'b0;
        dc0 = done_count;
        repeat (8) @(negedge clk);
        check("t5_no_done", 32'(done_count - dc0), 32'd0);
        op(4'b1101, 4'b0010, 1'b0, lat, bc);
        check("t5_fresh_diff", 32'(diff), 32'hB);
        check("t5_fresh_bout", 32'(bout), 32'd0);

        // 6: exhaustive sweep
        repeat (3) @(negedge clk);
        dc0 = done_count;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    @(negedge clk);
                    op(4'(ai), 4'(bi), 1'(ci), lat, bc);
                    ev = 5'(ai - bi - ci);
                    check("sweep_result", 32'({bout, diff}), 32'(ev));
                    check("sweep_latency", 32'(lat), 32'd4);
                end
            end
        end
        repeat (3) @(negedge clk);
        check("sweep_done_count", 32'(done_count - dc0), 32'd512);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
